// File: rtl/pvs_pkg.sv
// Shared types and helpers for the pump/valve sequencer.
//   state_t    : sequencer FSM states
//   phase_t    : pump phase index, wide enough for any practical PHASES
//   next_phase : one-step phase advance with wrap, forward or reverse
package pvs_pkg;

  localparam int PH_W = 8;

  typedef logic [PH_W-1:0] phase_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Forward walks 0,1,..,P-1,0; reverse walks 0,P-1,..,1,0.
  function automatic phase_t next_phase(input phase_t phase, input logic dir,
                                        input int phases);
    phase_t last;
    last = phase_t'(phases - 1);
    if (!dir)
      next_phase = (phase == last) ? '0 : phase + 1'b1;
    else
      next_phase = (phase == '0) ? last : phase - 1'b1;
  endfunction

endpackage

// File: rtl/pump_phase_gen.sv
// One-cold pattern generator for a single peristaltic pump.
//   phase   in  : shared phase index
//   en      in  : pump driven this cycle
//   pattern out : PHASES-bit drive, bit == phase is 0 (open), all others 1;
//                 all 1s when not enabled
module pump_phase_gen
  import pvs_pkg::*;
#(
  parameter int PHASES = 3
) (
  input  phase_t            phase,
  input  logic              en,
  output logic [PHASES-1:0] pattern
);

  always_comb begin
    pattern = '1;
    if (en) begin
      for (int k = 0; k < PHASES; k++) begin
        if (phase == phase_t'(k)) pattern[k] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/pump_valve_sequencer.sv
// Step sequencer for the pneumatic valve and peristaltic pump lines of an
// MFDA chip. One command per handshake: valve pattern, pumps to run,
// direction, stroke count and per-phase dwell. Drives the lines for the step,
// then pulses done (qualified by aborted).
// Optional build macro PVS_FLUSH_EN adds a FLUSH_CYC-cycle flush phase after
// RUN and the valve_flush / pump_flush ports.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cmd_valid/ready   step command handshake (ready only in IDLE)
//   cmd_valves        valve pattern for the step (1 = closed)
//   cmd_pump_en       per-pump run enable
//   cmd_dir           0 forward, 1 reverse
//   cmd_strokes       full pump cycles, 0 = dwell-only step
//   cmd_div           each phase held cmd_div+1 cycles
//   abort             end the current step early
//   valve_ctrl        registered valve drive
//   pump_ctrl         registered pump drive, pump i at [i*PHASES +: PHASES]
//   busy, done, aborted  step status
//   valve_flush, pump_flush  flush drive (PVS_FLUSH_EN only)
module pump_valve_sequencer
  import pvs_pkg::*;
#(
  parameter int N_VALVES  = 11,
  parameter int N_PUMPS   = 1,
  parameter int PHASES    = 3,
  parameter int CNT_W     = 16,
  parameter int DIV_W     = 8,
  parameter int FLUSH_CYC = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [N_VALVES-1:0]         cmd_valves,
  input  logic [N_PUMPS-1:0]          cmd_pump_en,
  input  logic                        cmd_dir,
  input  logic [CNT_W-1:0]            cmd_strokes,
  input  logic [DIV_W-1:0]            cmd_div,
  input  logic                        abort,
  output logic [N_VALVES-1:0]         valve_ctrl,
  output logic [N_PUMPS*PHASES-1:0]   pump_ctrl,
  output logic                        busy,
  output logic                        done,
  output logic                        aborted
`ifdef PVS_FLUSH_EN
  ,
  output logic [N_VALVES-1:0]         valve_flush,
  output logic [N_PUMPS*PHASES-1:0]   pump_flush
`endif
);

  localparam int FL_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  state_t             state;
  phase_t             phase_r;
  phase_t             ph_cnt_r;
  logic [DIV_W-1:0]   timer_r;
  logic [CNT_W-1:0]   strokes_r;

  // Step fields captured at accept; only meaningful while a step runs.
  logic [N_PUMPS-1:0] pump_en_r;
  logic               dir_r;
  logic [DIV_W-1:0]   div_r;
`ifdef PVS_FLUSH_EN
  logic [N_VALVES-1:0] valves_r;
  logic [FL_W-1:0]     flush_cnt_r;
`endif

  logic                      accept;
  logic                      tick;
  logic                      stroke_end;
  logic                      run_end;
  logic                      abort_hit;
  logic                      nat_end;
  logic                      to_done;
  phase_t                    phase_nxt;
  logic                      pump_on_nxt;
  logic [N_PUMPS-1:0]        pump_en_nxt;
  logic [N_PUMPS*PHASES-1:0] pump_pattern;

  assign cmd_ready = (state == IDLE);
  assign accept    = (state == IDLE) && cmd_valid;

  always_comb begin
    tick       = (timer_r == '0);
    stroke_end = tick && (ph_cnt_r == phase_t'(PHASES - 1));
    // Dwell-only steps end after one divider period; pumping steps end on
    // the final phase of the final stroke.
    run_end    = (strokes_r == '0) ? tick
                                   : (stroke_end && (strokes_r == CNT_W'(1)));
    abort_hit  = abort && ((state == RUN) || (state == FLUSH));
`ifdef PVS_FLUSH_EN
    nat_end    = (state == FLUSH) && (flush_cnt_r == '0);
`else
    nat_end    = (state == RUN) && run_end;
`endif
    to_done    = abort_hit || nat_end;
  end

  // Next-cycle pump drive is decided here so pump_ctrl can be registered
  // and still line up with the state it belongs to.
  always_comb begin
    phase_nxt   = phase_r;
    pump_on_nxt = 1'b0;
    pump_en_nxt = pump_en_r;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          phase_nxt   = '0;
          pump_on_nxt = (cmd_strokes != '0);
          pump_en_nxt = cmd_pump_en;
        end
      end
      RUN: begin
        if (!abort && !run_end) begin
          pump_on_nxt = (strokes_r != '0);
          if (tick) phase_nxt = next_phase(phase_r, dir_r, PHASES);
        end
      end
      default: ;
    endcase
  end

  for (genvar i = 0; i < N_PUMPS; i++) begin : g_pump
    pump_phase_gen #(
      .PHASES (PHASES)
    ) u_phase_gen (
      .phase   (phase_nxt),
      .en      (pump_on_nxt && pump_en_nxt[i]),
      .pattern (pump_pattern[i*PHASES +: PHASES])
    );
  end

  // Command capture: data only, loaded on accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      pump_en_r <= cmd_pump_en;
      dir_r     <= cmd_dir;
      div_r     <= cmd_div;
`ifdef PVS_FLUSH_EN
      valves_r  <= cmd_valves;
`endif
    end
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      phase_r     <= '0;
      ph_cnt_r    <= '0;
      timer_r     <= '0;
      strokes_r   <= '0;
      valve_ctrl  <= '1;
      pump_ctrl   <= '1;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
`ifdef PVS_FLUSH_EN
      flush_cnt_r <= '0;
      valve_flush <= '0;
      pump_flush  <= '0;
`endif
    end else begin
      done      <= 1'b0;
      phase_r   <= phase_nxt;
      pump_ctrl <= pump_pattern;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            state      <= RUN;
            busy       <= 1'b1;
            valve_ctrl <= cmd_valves;
            timer_r    <= cmd_div;
            ph_cnt_r   <= '0;
            strokes_r  <= cmd_strokes;
          end
        end
        RUN: begin
          if (tick) begin
            timer_r  <= div_r;
            ph_cnt_r <= (ph_cnt_r == phase_t'(PHASES - 1)) ? '0
                                                           : ph_cnt_r + 1'b1;
            if (stroke_end && (strokes_r != '0)) strokes_r <= strokes_r - 1'b1;
          end else begin
            timer_r <= timer_r - 1'b1;
          end
`ifdef PVS_FLUSH_EN
          if (run_end) begin
            state       <= FLUSH;
            valve_ctrl  <= '1;
            flush_cnt_r <= FL_W'(FLUSH_CYC - 1);
            valve_flush <= ~valves_r;
            for (int i = 0; i < N_PUMPS; i++)
              pump_flush[i*PHASES +: PHASES] <= {PHASES{pump_en_r[i]}};
          end
`endif
        end
        FLUSH: begin
`ifdef PVS_FLUSH_EN
          if (flush_cnt_r != '0) flush_cnt_r <= flush_cnt_r - 1'b1;
`endif
        end
        DONE: begin
          state   <= IDLE;
          aborted <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      // Step end: abort wins over a coincident natural end.
      if (to_done) begin
        state      <= DONE;
        busy       <= 1'b0;
        done       <= 1'b1;
        aborted    <= abort_hit;
        valve_ctrl <= '1;
`ifdef PVS_FLUSH_EN
        valve_flush <= '0;
        pump_flush  <= '0;
`endif
      end
    end
  end

endmodule
